// File: rtl/bt_at_cmd_streamer.sv
// Streams a Bluefruit AT command (prefix, optional payload, CR or CR+LF) one byte
// at a time over a valid/ready handshake toward the UART transmitter.
module bt_at_cmd_streamer #(
  parameter int MAX_PAYLOAD = 20,
  parameter int LEN_W       = 5,
  parameter int APPEND_LF   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_start,
  input  logic [1:0]               i_cmd_sel,
  input  logic [8*MAX_PAYLOAD-1:0] i_payload,
  input  logic [LEN_W-1:0]         i_payload_len,
  output logic [7:0]               o_tx_byte,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_cmd_err
);
  localparam int CNT_RAW = $clog2(MAX_PAYLOAD + 17);
  localparam int CNT_W   = (CNT_RAW > LEN_W) ? CNT_RAW : LEN_W;
  localparam int PI_W    = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  localparam logic [1:0] C_TX = 2'd0, C_RX = 2'd1, C_NAME = 2'd2;

  // Prefix ROMs, element 0 is the first character sent; shorter ones are zero padded.
  localparam logic [0:13][7:0] PFX_TX   = {"AT+BLEUARTTX=", 8'h00};
  localparam logic [0:13][7:0] PFX_RX   = {"AT+BLEUARTRX", 16'h0000};
  localparam logic [0:13][7:0] PFX_NAME = "AT+GAPDEVNAME=";

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_PAYLOAD, S_TERM} state_t;

  state_t                        r_state, w_next;
  logic [1:0]                    r_cmd;
  logic [MAX_PAYLOAD-1:0][7:0]   r_payload;
  logic [LEN_W-1:0]              r_len;
  logic [CNT_W-1:0]              r_idx;
  logic                          r_done, r_err;

  logic                          w_fire, w_bad, w_accept, w_skip_pl, w_phase_last;
  logic [CNT_W-1:0]              w_pfx_last;
  logic [7:0]                    w_pfx_byte;

  assign w_fire    = o_tx_valid & i_tx_ready;
  assign w_bad     = (i_cmd_sel == 2'd3) || (i_payload_len > LEN_W'(MAX_PAYLOAD));
  assign w_accept  = (r_state == S_IDLE) && i_start && !w_bad;
  assign w_skip_pl = (r_len == '0) || (r_cmd == C_RX);

  always_comb begin
    w_pfx_last = CNT_W'(12);
    w_pfx_byte = PFX_TX[r_idx[3:0]];
    case (r_cmd)
      C_RX: begin
        w_pfx_last = CNT_W'(11);
        w_pfx_byte = PFX_RX[r_idx[3:0]];
      end
      C_NAME: begin
        w_pfx_last = CNT_W'(13);
        w_pfx_byte = PFX_NAME[r_idx[3:0]];
      end
      default: ;
    endcase
  end

  always_comb begin
    w_phase_last = 1'b0;
    case (r_state)
      S_PREFIX:  w_phase_last = (r_idx == w_pfx_last);
      S_PAYLOAD: w_phase_last = (r_idx == CNT_W'(r_len) - CNT_W'(1));
      S_TERM:    w_phase_last = (r_idx == CNT_W'((APPEND_LF != 0) ? 1 : 0));
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_PREFIX;
      S_PREFIX:  if (w_fire && w_phase_last) w_next = w_skip_pl ? S_TERM : S_PAYLOAD;
      S_PAYLOAD: if (w_fire && w_phase_last) w_next = S_TERM;
      S_TERM:    if (w_fire && w_phase_last) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Byte counter restarts at every phase change, so it indexes the ROM, payload or terminator directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd     <= '0;
      r_payload <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= (r_state == S_TERM) && w_fire && w_phase_last;
      r_err  <= (r_state == S_IDLE) && i_start && w_bad;
      if (w_accept) begin
        r_cmd     <= i_cmd_sel;
        r_payload <= i_payload;
        r_len     <= i_payload_len;
        r_idx     <= '0;
      end else if (w_fire) begin
        r_idx <= (w_next != r_state) ? '0 : r_idx + CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_tx_byte  = 8'h00;
    o_tx_valid = (r_state != S_IDLE);
    o_busy     = (r_state != S_IDLE);
    o_done     = r_done;
    o_cmd_err  = r_err;
    case (r_state)
      S_PREFIX:  o_tx_byte = w_pfx_byte;
      S_PAYLOAD: o_tx_byte = r_payload[r_idx[PI_W-1:0]];
      S_TERM:    o_tx_byte = (r_idx == '0) ? 8'h0D : 8'h0A;
      default:   ;
    endcase
  end
endmodule

// File: tb/tb_bt_at_cmd_streamer.sv
// Scoreboard bench: two streamers (CR-only and CR+LF) checked against a string-level
// model of the expected AT command bytes, with random commands and ready patterns.
module tb_bt_at_cmd_streamer;
  localparam int MP = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [1:0]      start = '0;
  logic [1:0]      cmd_sel = '0;
  logic [8*MP-1:0] payload = '0;
  logic [4:0]      payload_len = '0;
  logic            tx_ready = 1'b0;
  logic [7:0]      tx_byte [2];
  logic            tx_valid [2];
  logic            busy [2];
  logic            done [2];
  logic            cmd_err [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    bt_at_cmd_streamer #(.MAX_PAYLOAD(MP), .LEN_W(5), .APPEND_LF(g)) u_dut (
      .clk(clk), .reset(reset), .i_start(start[g]), .i_cmd_sel(cmd_sel),
      .i_payload(payload), .i_payload_len(payload_len),
      .o_tx_byte(tx_byte[g]), .o_tx_valid(tx_valid[g]), .i_tx_ready(tx_ready),
      .o_busy(busy[g]), .o_done(done[g]), .o_cmd_err(cmd_err[g])
    );
  end

  int         checks = 0, errors = 0;
  int         rmode = 0;
  bit         m_busy [2];
  bit         exp_done [2];
  bit         exp_err [2];
  bit         hold_v [2];
  logic [7:0] hold_b [2];
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  logic [8:0] mon_e;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // tx_ready pattern: 0 always high, 1 toggling, 2 random
  always @(posedge clk) begin
    #1;
    case (rmode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom);
    endcase
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("done", k, 32'(done[k]), 32'(exp_done[k]));
      exp_done[k] = 1'b0;
      chk("cmd_err", k, 32'(cmd_err[k]), 32'(exp_err[k]));
      exp_err[k] = 1'b0;
      chk("busy", k, 32'(busy[k]), 32'(m_busy[k]));
      chk("tx_valid", k, 32'(tx_valid[k]), 32'(m_busy[k]));
      if (hold_v[k]) chk("hold", k, {23'd0, tx_valid[k], tx_byte[k]}, {23'd0, 1'b1, hold_b[k]});
      hold_v[k] = tx_valid[k] && !tx_ready;
      hold_b[k] = tx_byte[k];
      if (tx_valid[k] && tx_ready) begin
        if ((k == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
          checks++; errors++;
          $display("FAIL extra_byte inst%0d: got %0h expected nothing at %0t", k, tx_byte[k], $time);
        end else begin
          mon_e = (k == 0) ? q0.pop_front() : q1.pop_front();
          chk("tx_byte", k, 32'(tx_byte[k]), 32'(mon_e[7:0]));
          if (mon_e[8]) begin
            m_busy[k]   = 1'b0;
            exp_done[k] = 1'b1;
          end
        end
      end
    end
  end

  // Expected byte stream, built from the command text rather than from any counter.
  task automatic model(input int k, input logic [1:0] c, input logic [8*MP-1:0] p, input logic [4:0] l);
    string      s;
    logic [7:0] b [$];
    s = (c == 2'd0) ? "AT+BLEUARTTX=" : (c == 2'd1) ? "AT+BLEUARTRX" : "AT+GAPDEVNAME=";
    for (int i = 0; i < s.len(); i++) b.push_back(s[i]);
    if (c != 2'd1) for (int i = 0; i < int'(l); i++) b.push_back(p[8*i +: 8]);
    b.push_back(8'h0D);
    if (k == 1) b.push_back(8'h0A);
    foreach (b[i]) begin
      if (k == 0) q0.push_back({i == b.size() - 1, b[i]});
      else        q1.push_back({i == b.size() - 1, b[i]});
    end
  endtask

  function automatic logic [8*MP-1:0] rand_pay();
    logic [8*MP-1:0] p;
    for (int i = 0; i < MP; i++) p[8*i +: 8] = 8'($urandom_range(32, 126));
    return p;
  endfunction

  // Called just after a rising edge; returns just after the edge that samples start.
  task automatic issue(input int k, input logic [1:0] c, input logic [8*MP-1:0] p, input logic [4:0] l);
    bit acc, ok;
    acc = !m_busy[k];
    ok  = (c != 2'd3) && (int'(l) <= MP);
    start[k] = 1'b1; cmd_sel = c; payload = p; payload_len = l;
    @(posedge clk); #1;
    start[k] = 1'b0; cmd_sel = 2'($urandom); payload = rand_pay(); payload_len = 5'($urandom);
    if (acc && ok) begin
      m_busy[k] = 1'b1;
      model(k, c, p, l);
    end else if (acc) begin
      exp_err[k] = 1'b1;
    end
  endtask

  task automatic wait_idle(input int k, output int n);
    n = 0;
    while (m_busy[k] && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (m_busy[k]) begin
      checks++; errors++;
      $display("FAIL timeout inst%0d: got busy after %0d cycles expected idle", k, n);
      m_busy[k] = 1'b0;
    end
  endtask

  task automatic reset_mid();
    reset = 1'b1;
    #1;
    chk("reset_valid", 0, 32'(tx_valid[0]), 32'd0);
    chk("reset_busy", 0, 32'(busy[0]), 32'd0);
    q0.delete(); q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 1'b0; exp_done[k] = 1'b0; exp_err[k] = 1'b0; hold_v[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    logic [8*MP-1:0] p;
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_tx_byte", 0, 32'(tx_byte[0]), 32'd0);
    chk("rst_tx_valid", 0, 32'(tx_valid[0]), 32'd0);
    chk("rst_busy", 0, 32'(busy[0]), 32'd0);
    chk("rst_done", 0, 32'(done[0]), 32'd0);
    chk("rst_cmd_err", 0, 32'(cmd_err[0]), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // TX "ABCD", ready high: 18 bytes, last accepted 18 edges after the accept
    p = rand_pay(); p[31:0] = 32'h44434241;
    issue(0, 2'd0, p, 5'd4);
    wait_idle(0, n);
    chk("tx_latency", 0, 32'(n), 32'd18);

    // RX ignores payload and length
    issue(0, 2'd1, rand_pay(), 5'd7);
    wait_idle(0, n);
    chk("rx_latency", 0, 32'(n), 32'd13);

    // Toggling ready with an ignored start and new inputs mid-stream
    rmode = 1;
    issue(0, 2'd0, rand_pay(), 5'd2);
    repeat (3) @(posedge clk); #1;
    issue(0, 2'd2, rand_pay(), 5'd5);
    wait_idle(0, n);

    // Rejects, then maximum payload
    rmode = 0;
    issue(0, 2'd3, rand_pay(), 5'd4);
    issue(0, 2'd0, rand_pay(), 5'd21);
    @(posedge clk); #1;
    issue(0, 2'd0, rand_pay(), 5'd20);
    wait_idle(0, n);
    chk("max_latency", 0, 32'(n), 32'd34);

    // Reset after the fifth byte, then NAME with no payload
    issue(0, 2'd0, rand_pay(), 5'd6);
    repeat (5) @(posedge clk); #1;
    chk("pre_reset_q", 0, 32'(q0.size()), 32'd15);
    reset_mid();
    issue(0, 2'd2, rand_pay(), 5'd0);
    wait_idle(0, n);
    chk("name_latency", 0, 32'(n), 32'd15);

    // CR+LF instance, back-to-back start in the done cycle
    issue(1, 2'd0, rand_pay(), 5'd0);
    wait_idle(1, n);
    chk("lf_latency", 1, 32'(n), 32'd15);
    issue(1, 2'd2, rand_pay(), 5'd3);
    wait_idle(1, n);
    chk("lf_b2b_latency", 1, 32'(n), 32'd19);

    // Random commands and ready patterns on both instances
    for (int it = 0; it < 30; it++) begin
      int k;
      k = int'($urandom_range(0, 1));
      rmode = int'($urandom_range(0, 2));
      issue(k, 2'($urandom_range(0, 3)), rand_pay(), 5'($urandom_range(0, 22)));
      if ($urandom_range(0, 2) == 0) begin
        repeat (2) @(posedge clk); #1;
        issue(k, 2'($urandom_range(0, 3)), rand_pay(), 5'($urandom_range(0, 22)));
      end
      wait_idle(k, n);
    end

    rmode = 0;
    repeat (3) @(posedge clk); #1;
    chk("q0_drained", 0, 32'(q0.size()), 32'd0);
    chk("q1_drained", 1, 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
